// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: synchronises and debounces both phases, then turns
// Gray-code transitions into counter-compatible step/direction pulses.
module quad_step_decoder #(
  parameter int FILTER_LEN = 3,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clr_err,
  output logic             enable,
  output logic             up_down,
  output logic [CNT_W-1:0] count,
  output logic             err_pulse,
  output logic             err_sticky
);

  localparam int FW = 4;
  localparam int QW = 5;
  localparam logic [FW-1:0] FLT_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [QW-1:0] QUIET_MAX = QW'(FILTER_LEN + 2);

  typedef enum logic {INIT, TRACK} state_t;

  // Phase index 1 = A, 0 = B throughout.
  logic [1:0]    sync_m_q, sync_s_q;
  logic [1:0]    filt_q, filt_d, prev_q;
  logic [FW-1:0] fcnt_q [2];
  logic [FW-1:0] fcnt_d [2];
  logic [QW-1:0] quiet_q, quiet_d;
  state_t        state_q, state_d;

  logic             enable_q, up_down_q, err_pulse_q, err_sticky_q;
  logic [CNT_W-1:0] count_q;
  logic             step_up, step_dn, illegal;
  logic [1:0]       pos_prev, pos_new, delta;

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (sync_s_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FLT_LAST) filt_d[i] = sync_s_q[i];
        else                       fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  // Settling counter: consecutive cycles with both filters idle.
  always_comb begin
    quiet_d = '0;
    if (fcnt_q[0] == '0 && fcnt_q[1] == '0)
      quiet_d = (quiet_q == QUIET_MAX) ? quiet_q : quiet_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && quiet_q == QUIET_MAX) state_d = TRACK;
  end

  // Gray position 0..3 along the forward sequence; delta 1 = up, 3 = down, 2 = illegal.
  always_comb begin
    pos_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
    pos_new  = {filt_q[1], filt_q[1] ^ filt_q[0]};
    delta    = pos_new - pos_prev;
    step_up  = (state_q == TRACK) && (delta == 2'd1);
    step_dn  = (state_q == TRACK) && (delta == 2'd3);
    illegal  = (state_q == TRACK) && (delta == 2'd2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_m_q     <= '0;
      sync_s_q     <= '0;
      filt_q       <= '0;
      prev_q       <= '0;
      fcnt_q[0]    <= '0;
      fcnt_q[1]    <= '0;
      quiet_q      <= '0;
      enable_q     <= 1'b0;
      up_down_q    <= 1'b0;
      count_q      <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      sync_m_q     <= {quad_a, quad_b};
      sync_s_q     <= sync_m_q;
      filt_q       <= filt_d;
      prev_q       <= filt_q;
      fcnt_q[0]    <= fcnt_d[0];
      fcnt_q[1]    <= fcnt_d[1];
      quiet_q      <= quiet_d;
      enable_q     <= step_up | step_dn;
      err_pulse_q  <= illegal;
      if (step_up) begin
        up_down_q <= 1'b0;
        count_q   <= count_q + 1'b1;
      end else if (step_dn) begin
        up_down_q <= 1'b1;
        count_q   <= count_q - 1'b1;
      end
      if (illegal)      err_sticky_q <= 1'b1;
      else if (clr_err) err_sticky_q <= 1'b0;
    end
  end

  assign enable     = enable_q;
  assign up_down    = up_down_q;
  assign count      = count_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: expected step/error events are queued
// when the pins change and matched against the DUT output stream.
module tb_quad_step_decoder;

  localparam int FL  = 3;
  localparam int CW  = 4;
  localparam int LAT = FL + 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          quad_a = 1'b0, quad_b = 1'b0, clr_err = 1'b0;
  logic          enable, up_down, err_pulse, err_sticky;
  logic [CW-1:0] count;

  quad_step_decoder #(.FILTER_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b), .clr_err(clr_err),
    .enable(enable), .up_down(up_down), .count(count),
    .err_pulse(err_pulse), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int            cyc;
    logic          en;
    logic          ud;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t          sbq[$];
  exp_t          me;
  logic [1:0]    cur_ab = 2'b00;
  logic [CW-1:0] m_cnt  = '0;
  logic          m_ud   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int gpos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Drive a new {A,B} level at a falling edge and hold it for 'hold' cycles.
  task automatic drive_ab(input logic [1:0] ab, input int hold);
    exp_t e;
    int   d;
    @(negedge clk);
    quad_a = ab[1];
    quad_b = ab[0];
    d = (gpos(ab) - gpos(cur_ab) + 4) % 4;
    if (d != 0) begin
      e.cyc = cyc + LAT;
      e.en  = 1'b0;
      e.err = 1'b0;
      if (d == 1) begin
        m_cnt = m_cnt + 1'b1;
        m_ud  = 1'b0;
        e.en  = 1'b1;
      end else if (d == 3) begin
        m_cnt = m_cnt - 1'b1;
        m_ud  = 1'b1;
        e.en  = 1'b1;
      end else begin
        e.err = 1'b1;
      end
      e.ud  = m_ud;
      e.cnt = m_cnt;
      sbq.push_back(e);
    end
    cur_ab = ab;
    repeat (hold - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset && (enable || err_pulse)) begin
      if (sbq.size() == 0) begin
        check_eq("unexpected_evt", {30'd0, enable, err_pulse}, 32'd0);
      end else begin
        me = sbq.pop_front();
        check_eq("evt_cycle", cyc, me.cyc);
        check_eq("evt_enable", enable, me.en);
        check_eq("evt_up_down", up_down, me.ud);
        check_eq("evt_count", count, me.cnt);
        check_eq("evt_err", err_pulse, me.err);
      end
    end
  end

  initial begin
    #1 reset = 1'b0;
    #1;
    check_eq("rst_enable", enable, 0);
    check_eq("rst_up_down", up_down, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_err_pulse", err_pulse, 0);
    check_eq("rst_err_sticky", err_sticky, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    drive_ab(2'b01, 10); drive_ab(2'b11, 10); drive_ab(2'b10, 10); drive_ab(2'b00, 10);
    check_eq("fwd_count", count, 4);
    check_eq("fwd_up_down", up_down, 0);

    drive_ab(2'b10, 10); drive_ab(2'b11, 10); drive_ab(2'b01, 10); drive_ab(2'b00, 10);
    check_eq("rev_count_zero", count, 0);
    drive_ab(2'b10, 10); drive_ab(2'b11, 10); drive_ab(2'b01, 10);
    check_eq("wrap_count", count, 13);
    check_eq("wrap_up_down", up_down, 1);

    // 2-cycle glitch on A (state 01) must be discarded.
    @(negedge clk); quad_a = 1'b1;
    repeat (2) @(negedge clk); quad_a = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("glitch_count", count, 13);
    drive_ab(2'b11, 3); drive_ab(2'b01, 10);
    check_eq("pulse3_count", count, 13);
    check_eq("pulse3_up_down", up_down, 1);

    drive_ab(2'b00, 10);
    drive_ab(2'b11, 10);
    check_eq("illegal_sticky", err_sticky, 1);
    check_eq("illegal_count", count, 12);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check_eq("sticky_cleared", err_sticky, 0);
    repeat (3) @(negedge clk);

    drive_ab(2'b00, 1);
    repeat (LAT - 1) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check_eq("sticky_set_wins", err_sticky, 1);
    repeat (5) @(negedge clk);
    check_eq("sticky_held", err_sticky, 1);

    drive_ab(2'b01, 10); drive_ab(2'b11, 10);
    check_eq("pre_reset_count", count, 14);
    check_eq("sb_drain_1", sbq.size(), 0);

    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_count", count, 0);
    check_eq("async_rst_enable", enable, 0);
    check_eq("async_rst_up_down", up_down, 0);
    check_eq("async_rst_err_pulse", err_pulse, 0);
    check_eq("async_rst_err_sticky", err_sticky, 0);
    @(negedge clk);
    reset  = 1'b1;
    cur_ab = 2'b11;
    m_cnt  = '0;
    m_ud   = 1'b0;
    repeat (25) @(negedge clk);
    check_eq("init_count", count, 0);
    check_eq("init_err_sticky", err_sticky, 0);
    drive_ab(2'b10, 10);
    check_eq("post_init_count", count, 1);
    check_eq("post_init_up_down", up_down, 0);
    repeat (5) @(negedge clk);
    check_eq("sb_drain_2", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
